// File: rtl/button_events.sv
// Turns a debounced button level plus a slow tick strobe into press/release,
// short/long press and auto-repeat pulses; one instance per button.
module button_events #(
  parameter int CNT_W        = 8,
  parameter int LONG_TICKS   = 50,
  parameter int REPEAT_TICKS = 10
) (
  input  logic clk_i,
  input  logic rst_sync_i,
  input  logic tick_i,
  input  logic debounced_i,
  output logic press_o,
  output logic release_o,
  output logic short_press_o,
  output logic long_press_o,
  output logic repeat_press_o,
  output logic held_o
);

  typedef enum logic [1:0] {
    ARM,
    IDLE,
    HELD,
    LONG
  } state_e;

  // Compare against N-1 so cnt+1 never has to be formed at full width.
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);
  localparam bit               REPEAT_EN   = (REPEAT_TICKS != 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             held_q, held_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;

    case (state_q)
      ARM: begin
        // A button already down at reset release must be seen up before it counts.
        if (!debounced_i) state_d = IDLE;
      end
      IDLE: begin
        if (debounced_i) begin
          state_d = HELD;
          cnt_d   = '0;
          press_d = 1'b1;
        end
      end
      HELD: begin
        if (!debounced_i) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
          short_d   = 1'b1;
        end else if (tick_i) begin
          if (cnt_q == LONG_LAST) begin
            state_d = LONG;
            cnt_d   = '0;
            long_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      LONG: begin
        if (!debounced_i) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else if (tick_i && REPEAT_EN) begin
          if (cnt_q == REPEAT_LAST) begin
            cnt_d    = '0;
            repeat_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ARM;
    endcase

    held_d = (state_d == HELD) || (state_d == LONG);
  end

  always_ff @(posedge clk_i or posedge rst_sync_i) begin
    if (rst_sync_i) begin
      state_q   <= ARM;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      short_q   <= short_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  assign press_o        = press_q;
  assign release_o      = release_q;
  assign short_press_o  = short_q;
  assign long_press_o   = long_q;
  assign repeat_press_o = repeat_q;
  assign held_o         = held_q;

endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events: two instances (repeat every 2 ticks, repeat
// disabled) share the same stimulus; outputs packed {press,rel,short,long,rep,held}.
module tb_button_events;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic deb = 1'b0;

  logic a_press, a_rel, a_short, a_long, a_rep, a_held;
  logic b_press, b_rel, b_short, b_long, b_rep, b_held;
  logic [5:0] out_a, out_b;

  int vectors = 0;
  int miscompares = 0;
  int a_long_cnt = 0, a_rep_cnt = 0, b_long_cnt = 0, b_rep_cnt = 0;

  always #5 clk = ~clk;

  button_events #(.CNT_W(8), .LONG_TICKS(5), .REPEAT_TICKS(2)) dut_a (
    .clk_i(clk), .rst_sync_i(rst), .tick_i(tick), .debounced_i(deb),
    .press_o(a_press), .release_o(a_rel), .short_press_o(a_short),
    .long_press_o(a_long), .repeat_press_o(a_rep), .held_o(a_held)
  );

  button_events #(.CNT_W(8), .LONG_TICKS(5), .REPEAT_TICKS(0)) dut_b (
    .clk_i(clk), .rst_sync_i(rst), .tick_i(tick), .debounced_i(deb),
    .press_o(b_press), .release_o(b_rel), .short_press_o(b_short),
    .long_press_o(b_long), .repeat_press_o(b_rep), .held_o(b_held)
  );

  assign out_a = {a_press, a_rel, a_short, a_long, a_rep, a_held};
  assign out_b = {b_press, b_rel, b_short, b_long, b_rep, b_held};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply inputs for one clock, then sample just after the edge.
  task automatic step(input logic t, input logic d);
    tick = t;
    deb  = d;
    @(posedge clk);
    #1;
    if (a_long) a_long_cnt++;
    if (a_rep)  a_rep_cnt++;
    if (b_long) b_long_cnt++;
    if (b_rep)  b_rep_cnt++;
  endtask

  task automatic chk2(input string tag, input logic [5:0] exp_a, input logic [5:0] exp_b);
    chk({tag, " a"}, 32'(out_a), 32'(exp_a));
    chk({tag, " b"}, 32'(out_b), 32'(exp_b));
    $display("%s: a=%b b=%b", tag, out_a, out_b);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk2("reset", 6'b000000, 6'b000000);
    rst = 1'b0;

    // 1: short press of 3 ticks
    step(0, 0);
    chk2("t1 arm->idle", 6'b000000, 6'b000000);
    step(0, 1);
    chk2("t1 press", 6'b100001, 6'b100001);
    for (int k = 0; k < 3; k++) begin
      step(1, 1);
      chk2("t1 tick", 6'b000001, 6'b000001);
      step(0, 1);
    end
    step(0, 0);
    chk2("t1 release", 6'b011000, 6'b011000);
    step(0, 0);
    chk2("t1 idle", 6'b000000, 6'b000000);

    // 2: hold 10 ticks; long on 5th, repeats on 7th and 9th (dut_a only)
    step(0, 1);
    chk2("t2 press", 6'b100001, 6'b100001);
    for (int k = 1; k <= 10; k++) begin
      logic lp, rp;
      lp = (k == 5);
      rp = (k == 7) || (k == 9);
      step(1, 1);
      chk2($sformatf("t2 tick%0d", k), {3'b000, lp, rp, 1'b1}, {3'b000, lp, 1'b0, 1'b1});
      step(0, 1);
      chk2($sformatf("t2 gap%0d", k), 6'b000001, 6'b000001);
    end
    step(0, 0);
    chk2("t2 release", 6'b010000, 6'b010000);

    // 3: button held through reset release
    deb = 1'b1;
    rst = 1'b1;
    step(0, 1);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1, 1);
      chk2("t3 held in arm", 6'b000000, 6'b000000);
    end
    step(0, 0);
    chk2("t3 drop", 6'b000000, 6'b000000);
    step(0, 1);
    chk2("t3 repress", 6'b100001, 6'b100001);
    step(0, 0);
    chk2("t3 release", 6'b011000, 6'b011000);

    // 4: release coincides with the 5th tick
    step(0, 1);
    chk2("t4 press", 6'b100001, 6'b100001);
    for (int k = 0; k < 4; k++) step(1, 1);
    chk2("t4 before", 6'b000001, 6'b000001);
    step(1, 0);
    chk2("t4 release wins", 6'b011000, 6'b011000);

    // 5: 200 ticks held; dut_b never repeats, dut_a repeats on ticks 7,9..199
    step(0, 0);
    a_long_cnt = 0; a_rep_cnt = 0; b_long_cnt = 0; b_rep_cnt = 0;
    step(0, 1);
    for (int k = 0; k < 200; k++) step(1, 1);
    chk("t5 b long count", 32'(b_long_cnt), 32'd1);
    chk("t5 b repeat count", 32'(b_rep_cnt), 32'd0);
    chk("t5 a long count", 32'(a_long_cnt), 32'd1);
    chk("t5 a repeat count", 32'(a_rep_cnt), 32'd97);
    $display("t5: long a=%0d b=%0d repeat a=%0d b=%0d", a_long_cnt, b_long_cnt, a_rep_cnt, b_rep_cnt);
    step(0, 0);
    chk2("t5 release", 6'b010000, 6'b010000);

    // 6: reset while in LONG
    step(0, 1);
    for (int k = 0; k < 6; k++) step(1, 1);
    chk2("t6 in long", 6'b000001, 6'b000001);
    #2;
    rst = 1'b1;
    #1;
    chk2("t6 async clear", 6'b000000, 6'b000000);
    step(0, 1);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1, 1);
      chk2("t6 still held", 6'b000000, 6'b000000);
    end
    step(0, 0);
    chk2("t6 drop silent", 6'b000000, 6'b000000);
    step(0, 1);
    chk2("t6 press", 6'b100001, 6'b100001);
    step(0, 1);
    chk2("t6 pulse one clk", 6'b000001, 6'b000001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
